// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier family.
//   state_e      : controller states (IDLE / RUN / FINISH)
//   MAX_W        : widest vector the helpers operate on
//   cond_negate  : two's-complement negate when neg is set
//   magnitude    : absolute value of a width-bit operand (raw bits when unsigned)
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    localparam int unsigned MAX_W = 256;

    function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] val,
                                                     input logic             neg);
        return neg ? (~val + 1'b1) : val;
    endfunction

    // val must be zero-extended from width bits; the low width bits of the
    // result hold the magnitude, including 2^(width-1) for the most negative value.
    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] val,
                                                   input logic             is_signed,
                                                   input int unsigned      width);
        return cond_negate(val, is_signed && val[width-1]);
    endfunction

endpackage

// File: rtl/seq_mult_pw_core.sv
// shift_add_core: accumulator / shift / count datapath of the shift-add multiplier.
//   clk, rst          : clock, synchronous active-high reset
//   load_i            : load operand magnitudes, clear accumulator, count = WIDTH
//   step_i            : perform one shift-add iteration
//   mcand_i, mplr_i   : operand magnitudes (WIDTH bits)
//   acc_o             : 2*WIDTH accumulator
//   count_last_o      : the current step is the final one of the full loop
//   mplr_next_zero_o  : multiplier is zero after the current step's shift
module shift_add_core
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplr_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               count_last_o,
    output logic               mplr_next_zero_o
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;  // multiplicand pre-shifted by iteration index
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      count_q, count_d;

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        count_d = count_q;
        if (load_i) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mcand_i};
            mplr_d  = mplr_i;
            count_d = CW'(WIDTH);
        end else if (step_i) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            count_q <= count_d;
        end
    end

    assign acc_o            = acc_q;
    assign count_last_o     = (count_q == CW'(1));
    assign mplr_next_zero_o = (mplr_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/seq_mult_pw.sv
// seq_mult_pw: handshaked WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted when start && ready
//   signed_mode   : 1 = two's-complement operands (sampled with start)
//   multiplicand  : operand A (sampled with start)
//   multiplier    : operand B (sampled with start)
//   ready / busy  : idle / working
//   result        : product, held until the next done
//   done          : one-cycle pulse when a new result is valid
// WIDTH must be in 2..64; EARLY_EXIT stops once the remaining multiplier bits are zero.
module seq_mult_pw
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic [2*WIDTH-1:0] result,
    output logic               done
);
    state_e             state_q, state_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done_q, done_d;

    logic               load, step;
    logic [MAX_W-1:0]   mcand_ext, mplr_ext, res_ext;
    logic [WIDTH-1:0]   mcand_mag, mplr_mag;
    logic [2*WIDTH-1:0] acc;
    logic               count_last, mplr_next_zero;
    logic               unused_hi;

    shift_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk              (clk),
        .rst              (rst),
        .load_i           (load),
        .step_i           (step),
        .mcand_i          (mcand_mag),
        .mplr_i           (mplr_mag),
        .acc_o            (acc),
        .count_last_o     (count_last),
        .mplr_next_zero_o (mplr_next_zero)
    );

    always_comb begin
        mcand_ext = magnitude(MAX_W'(multiplicand), signed_mode, WIDTH);
        mplr_ext  = magnitude(MAX_W'(multiplier), signed_mode, WIDTH);
        res_ext   = cond_negate(MAX_W'(acc), neg_q);
        mcand_mag = mcand_ext[WIDTH-1:0];
        mplr_mag  = mplr_ext[WIDTH-1:0];
        unused_hi = ^{mcand_ext[MAX_W-1:WIDTH], mplr_ext[MAX_W-1:WIDTH],
                      res_ext[MAX_W-1:2*WIDTH]};

        state_d  = state_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    state_d = (EARLY_EXIT && (mplr_mag == '0)) ? FINISH : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_last || (EARLY_EXIT && mplr_next_zero)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = res_ext[2*WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign busy   = ~ready;
    assign result = result_q;
    assign done   = done_q;

endmodule
